logo_sprite_engine: RTL and testbench

//  Pixel-pipeline stage sitting between the VGA timing generator and the logo ROM.

---
 rtl/logo_sprite_engine.sv | 159 +++++++++++++++
 tb/tb_logo_sprite_engine.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/logo_sprite_engine.sv
// Bouncing-logo pixel stage: owns logo position, addresses the logo ROM and
// produces RRRGGGBB colour two cycles after the pixel coordinates, syncs aligned.
module logo_sprite_engine #(
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter int          LOGO_W    = 160,
  parameter int          LOGO_H    = 120,
  parameter int          STEP      = 2,
  parameter logic [7:0]  BG_COLOR  = 8'h00,
  parameter bit          KEY_EN    = 1'b1,
  parameter logic [7:0]  KEY_COLOR = 8'hE3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_tick,
  input  logic        pause,
  output logic [15:0] rom_addr,
  output logic        rom_re,
  output logic        rom_ce,
  input  logic [7:0]  rom_data,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int X_MAX = H_RES - LOGO_W;
  localparam int Y_MAX = V_RES - LOGO_H;

  typedef enum logic {MOVE_POS = 1'b0, MOVE_NEG = 1'b1} dir_e;

  dir_e        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [9:0]  logo_x_q, logo_x_d, logo_y_q, logo_y_d;

  logic [15:0] rom_addr_q, rom_addr_d;
  logic        hit_q, vid_q;
  logic [7:0]  rgb_q, rgb_d;
  logic [1:0]  hs_q, vs_q;

  logic [10:0] x_end, y_end;
  logic        hit;
  logic [9:0]  dx, dy;
  logic [16:0] addr_full;
  logic        unused_addr_msb;

  function automatic logic [7:0] pix_color(input logic vid, input logic hit_in,
                                           input logic [7:0] data);
    if (!vid)
      return 8'h00;
    else if (hit_in && !(KEY_EN && data == KEY_COLOR))
      return data;
    else
      return BG_COLOR;
  endfunction

  // Motion FSM: one step per unpaused frame tick, clamped at the screen edge.
  always_comb begin
    logo_x_d = logo_x_q;
    logo_y_d = logo_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    if (frame_tick && !pause) begin
      case (dir_x_q)
        MOVE_POS: begin
          if ({1'b0, logo_x_q} + 11'(STEP) >= 11'(X_MAX)) begin
            logo_x_d = 10'(X_MAX);
            dir_x_d  = MOVE_NEG;
          end else begin
            logo_x_d = logo_x_q + 10'(STEP);
          end
        end
        default: begin
          if (logo_x_q <= 10'(STEP)) begin
            logo_x_d = '0;
            dir_x_d  = MOVE_POS;
          end else begin
            logo_x_d = logo_x_q - 10'(STEP);
          end
        end
      endcase
      case (dir_y_q)
        MOVE_POS: begin
          if ({1'b0, logo_y_q} + 11'(STEP) >= 11'(Y_MAX)) begin
            logo_y_d = 10'(Y_MAX);
            dir_y_d  = MOVE_NEG;
          end else begin
            logo_y_d = logo_y_q + 10'(STEP);
          end
        end
        default: begin
          if (logo_y_q <= 10'(STEP)) begin
            logo_y_d = '0;
            dir_y_d  = MOVE_POS;
          end else begin
            logo_y_d = logo_y_q - 10'(STEP);
          end
        end
      endcase
    end
  end

  // Stage 1: hit test and ROM address against the current logo position.
  always_comb begin
    x_end     = {1'b0, logo_x_q} + 11'(LOGO_W - 1);
    y_end     = {1'b0, logo_y_q} + 11'(LOGO_H - 1);
    hit       = video_on &&
                (pixel_x >= logo_x_q) && ({1'b0, pixel_x} <= x_end) &&
                (pixel_y >= logo_y_q) && ({1'b0, pixel_y} <= y_end);
    dx        = pixel_x - logo_x_q;
    dy        = pixel_y - logo_y_q;
    addr_full = {7'd0, dy} * 17'(LOGO_W) + {7'd0, dx};
    rom_addr_d = hit ? addr_full[15:0] : rom_addr_q;
  end

  assign unused_addr_msb = addr_full[16];

  // Stage 2: colour from ROM data returned for the stage-1 address.
  always_comb begin
    rgb_d = pix_color(vid_q, hit_q, rom_data);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      logo_x_q   <= '0;
      logo_y_q   <= '0;
      dir_x_q    <= MOVE_POS;
      dir_y_q    <= MOVE_POS;
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
      vid_q      <= 1'b0;
      rgb_q      <= '0;
      hs_q       <= '0;
      vs_q       <= '0;
    end else begin
      logo_x_q   <= logo_x_d;
      logo_y_q   <= logo_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      rom_addr_q <= rom_addr_d;
      hit_q      <= hit;
      vid_q      <= video_on;
      rgb_q      <= rgb_d;
      hs_q       <= {hs_q[0], hsync_in};
      vs_q       <= {vs_q[0], vsync_in};
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_re    = hit_q;
  assign rom_ce    = hit_q;
  assign rgb       = rgb_q;
  assign hsync_out = hs_q[1];
  assign vsync_out = vs_q[1];

endmodule

// File: tb/tb_logo_sprite_engine.sv
// Randomized bench for logo_sprite_engine with a frame-level reference model.
module tb_logo_sprite_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic        frame_tick = 1'b0, pause = 1'b0;
  logic [15:0] rom_addr;
  logic        rom_re, rom_ce;
  logic [7:0]  rom_data, rgb;
  logic        hsync_out, vsync_out;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int   mx, my;
  bit   mneg_x, mneg_y;
  int   e_addr;
  bit   e_hit, e_vid;
  int   e_rgb;
  bit   hs_hist[$], vs_hist[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_model(input logic [15:0] a);
    if (a == 16'd485) return 8'h1C;
    if (a[3:0] == 4'h7) return 8'hE3;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign rom_data = rom_model(rom_addr);

  logo_sprite_engine dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_tick(frame_tick), .pause(pause), .rom_addr(rom_addr),
    .rom_re(rom_re), .rom_ce(rom_ce), .rom_data(rom_data), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the bouncing position by one frame along one axis.
  task automatic bounce(inout int pos, inout bit neg, input int lim);
    if (!neg) begin
      if (pos + 2 >= lim) begin pos = lim; neg = 1; end
      else pos = pos + 2;
    end else begin
      if (pos <= 2) begin pos = 0; neg = 0; end
      else pos = pos - 2;
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mneg_x = 0; mneg_y = 0;
    e_addr = 0; e_hit = 0; e_vid = 0; e_rgb = 0;
    hs_hist = '{0, 0}; vs_hist = '{0, 0};
  endtask

  // Apply one pixel-clock worth of inputs, update the model, then compare.
  task automatic cycle(input bit rst, input int x, input int y, input bit vid,
                       input bit hs, input bit vs, input bit ft, input bit ps);
    logic [7:0] d;
    bit hit;
    rst_n = rst; pixel_x = 10'(x); pixel_y = 10'(y); video_on = vid;
    hsync_in = hs; vsync_in = vs; frame_tick = ft; pause = ps;
    if (!rst) begin
      model_reset();
    end else begin
      d = rom_model(16'(e_addr));
      if (!e_vid) e_rgb = 0;
      else if (e_hit && d != 8'hE3) e_rgb = d;
      else e_rgb = 0;
      hit = vid && x >= mx && x < mx + 160 && y >= my && y < my + 120;
      if (hit) e_addr = (y - my) * 160 + (x - mx);
      e_hit = hit; e_vid = vid;
      hs_hist.push_back(hs); void'(hs_hist.pop_front());
      vs_hist.push_back(vs); void'(vs_hist.pop_front());
      if (ft && !ps) begin
        bounce(mx, mneg_x, 480);
        bounce(my, mneg_y, 360);
      end
    end
    @(posedge clk); #1;
    check_val("rom_addr", 32'(rom_addr), 32'(e_addr));
    check_val("rom_re", 32'(rom_re), 32'(e_hit));
    check_val("rom_ce", 32'(rom_ce), 32'(e_hit));
    check_val("rgb", 32'(rgb), 32'(e_rgb));
    check_val("hsync_out", 32'(hsync_out), 32'(hs_hist[0]));
    check_val("vsync_out", 32'(vsync_out), 32'(vs_hist[0]));
  endtask

  task automatic rand_cycle(input bit rst, input bit ft, input bit ps);
    int x, y;
    x = mx + int'($urandom_range(0, 200)) - 20;
    y = my + int'($urandom_range(0, 160)) - 20;
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    cycle(rst, x, y, ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), ft, ps);
  endtask

  task automatic check_pos(input string tag);
    check_val({tag, "_x"}, 32'(dut.logo_x_q), 32'(mx));
    check_val({tag, "_y"}, 32'(dut.logo_y_q), 32'(my));
    check_val({tag, "_dx"}, 32'(dut.dir_x_q), 32'(mneg_x));
    check_val({tag, "_dy"}, 32'(dut.dir_y_q), 32'(mneg_y));
  endtask

  initial begin
    int px, py;
    model_reset();
    // reset held with toggling inputs
    for (int i = 0; i < 3; i++) rand_cycle(0, 1, 0);
    check_val("rst_rgb", 32'(rgb), 32'h0);
    check_val("rst_re", 32'(rom_re), 32'h0);
    check_val("rst_x", 32'(dut.logo_x_q), 32'd0);
    cycle(1, 700, 500, 0, 0, 0, 1, 0);
    check_val("tick1_x", 32'(dut.logo_x_q), 32'd2);
    check_val("tick1_y", 32'(dut.logo_y_q), 32'd2);

    // addressing at (0,0)
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 5, 3, 1, 0, 0, 0, 0);
    check_val("addr485", 32'(rom_addr), 32'd485);
    check_val("addr485_re", 32'(rom_re), 32'd1);
    cycle(1, 200, 0, 1, 0, 0, 0, 0);
    check_val("rgb_1C", 32'(rgb), 32'h1C);
    check_val("outside_re", 32'(rom_re), 32'd0);
    cycle(1, 7, 0, 0, 0, 0, 0, 0);
    check_val("outside_rgb", 32'(rgb), 32'h00);
    cycle(1, 7, 0, 1, 0, 0, 0, 0);
    check_val("blank_rgb", 32'(rgb), 32'h00);
    cycle(1, 7, 0, 1, 0, 0, 0, 0);
    check_val("key_addr", 32'(rom_addr), 32'd7);
    check_val("key_rgb", 32'(rgb), 32'h00);

    // bounce from reset
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 240; i++) begin
      rand_cycle(1, 1, 0);
      if (i == 180) begin
        check_val("y_peak", 32'(dut.logo_y_q), 32'd360);
        check_val("y_rev", 32'(dut.dir_y_q), 32'd1);
      end
    end
    check_val("x_peak", 32'(dut.logo_x_q), 32'd480);
    check_val("x_rev", 32'(dut.dir_x_q), 32'd1);
    rand_cycle(1, 1, 0);
    check_val("x_back", 32'(dut.logo_x_q), 32'd478);

    // pause freezes position
    px = mx; py = my;
    for (int i = 0; i < 10; i++) rand_cycle(1, 1, 1);
    check_val("pause_x", 32'(dut.logo_x_q), 32'(px));
    check_val("pause_y", 32'(dut.logo_y_q), 32'(py));
    rand_cycle(1, 1, 0);
    check_val("resume_x", 32'(dut.logo_x_q), 32'(px - 2));
    check_pos("resume");

    // random traffic with occasional mid-line reset
    for (int i = 0; i < 3000; i++)
      rand_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0));
    check_pos("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
